// File: rtl/pos_filter_pkg.sv
// Shared constants, state encoding and saturation helper for the ADC position filter.
package pos_filter_pkg;

  localparam logic [15:0] OFFSET_DEFAULT = 16'h8000;

  // Boxcar window is 2^LOG2_AVG samples.
  localparam int LOG2_AVG_MIN = 0;
  localparam int LOG2_AVG_MAX = 5;

  localparam logic [15:0]        POS_MAX = 16'h7FFF;
  localparam logic [15:0]        POS_MIN = 16'h8000;
  localparam logic signed [16:0] AVG_HI  = 17'sd32767;
  localparam logic signed [16:0] AVG_LO  = -17'sd32768;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } filt_state_e;

  typedef struct packed {
    logic [15:0] pos;
    logic        sat;
  } sat_word_t;

  function automatic sat_word_t sat16(input logic signed [16:0] avg);
    sat_word_t r;
    if (avg > AVG_HI) begin
      r.pos = POS_MAX;
      r.sat = 1'b1;
    end else if (avg < AVG_LO) begin
      r.pos = POS_MIN;
      r.sat = 1'b1;
    end else begin
      r.pos = avg[15:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pos_ring_buf.sv
// Register-based ring buffer of 17-bit signed differences; exposes the entry about to be overwritten.
module pos_ring_buf #(
  parameter int LOG2_AVG = 3
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  input  logic        clr,
  input  logic        we,
  input  logic [16:0] wdata,
  output logic [16:0] oldest
);

  localparam int DEPTH = 1 << LOG2_AVG;
  localparam int PW    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [16:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  assign oldest = mem[wr_ptr];

  // Entries are zeroed on clear so the running sum needs no special case while filling.
  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adc_pos_filter.sv
// ADC position conditioning: new-conversion detect, offset removal, boxcar average, 16-bit saturation.
//
// state   | meaning
// ST_FILL | window not yet full since reset/calibration; no output strobes
// ST_RUN  | window full; every accepted sample produces a strobe 3 cycles later
module adc_pos_filter
  import pos_filter_pkg::*;
#(
  parameter int          LOG2_AVG = 3,
  parameter logic [15:0] OFFSET   = OFFSET_DEFAULT
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  input  logic        din_valid,
  input  logic [15:0] din,
  input  logic        cal_req,
  output logic        pos_valid,
  output logic [15:0] pos,
  output logic        pos_sat,
  output logic        primed
);

  localparam int SW = 17 + LOG2_AVG;
  localparam logic [LOG2_AVG:0] WIN_CNT  = (LOG2_AVG + 1)'(1 << LOG2_AVG);
  localparam logic [LOG2_AVG:0] WIN_LAST = (LOG2_AVG + 1)'((1 << LOG2_AVG) - 1);

  if (LOG2_AVG < LOG2_AVG_MIN || LOG2_AVG > LOG2_AVG_MAX) begin : g_bad_log2
    $error("adc_pos_filter: LOG2_AVG out of range");
  end

  logic               din_valid_q;
  logic               acc;
  logic               cal_pend;
  logic               cal_hit;
  logic [15:0]        offset_reg;

  logic               s1_vld;
  logic               s1_cal;
  logic signed [16:0] s1_diff;

  logic               wr_en;
  logic               buf_clr;
  logic [16:0]        oldest;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_nxt;
  logic [LOG2_AVG:0]  fill_cnt;
  logic               s2_emit;

  logic signed [16:0] avg;
  sat_word_t          sat_w;

  filt_state_e        state;
  filt_state_e        state_nxt;

  assign acc     = din_valid & ~din_valid_q;
  assign cal_hit = acc & (cal_pend | cal_req);

  // Stage 1: capture the new code as an offset-removed difference.
  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      din_valid_q <= 1'b0;
      cal_pend    <= 1'b0;
      offset_reg  <= OFFSET;
      s1_vld      <= 1'b0;
      s1_cal      <= 1'b0;
      s1_diff     <= '0;
    end else begin
      din_valid_q <= din_valid;
      cal_pend    <= (cal_pend | cal_req) & ~acc;
      if (cal_hit) offset_reg <= din;
      s1_vld  <= acc;
      s1_cal  <= cal_hit;
      s1_diff <= $signed({1'b0, din}) - $signed({1'b0, offset_reg});
    end
  end

  // Stage 2: running sum and window. A calibration sample only empties the window.
  assign wr_en   = s1_vld & ~s1_cal;
  assign buf_clr = s1_vld &  s1_cal;
  assign sum_nxt = sum + SW'(s1_diff) - SW'($signed(oldest));

  pos_ring_buf #(
    .LOG2_AVG (LOG2_AVG)
  ) u_ring (
    .clk_ref  (clk_ref),
    .sys_rstn (sys_rstn),
    .clr      (buf_clr),
    .we       (wr_en),
    .wdata    (s1_diff),
    .oldest   (oldest)
  );

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sum      <= '0;
      fill_cnt <= '0;
      s2_emit  <= 1'b0;
      state    <= ST_FILL;
    end else begin
      if (buf_clr) begin
        sum      <= '0;
        fill_cnt <= '0;
      end else if (wr_en) begin
        sum      <= sum_nxt;
        fill_cnt <= (fill_cnt == WIN_CNT) ? fill_cnt : fill_cnt + 1'b1;
      end
      s2_emit <= wr_en & (state_nxt == ST_RUN);
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (wr_en && fill_cnt == WIN_LAST) state_nxt = ST_RUN;
      ST_RUN:  if (buf_clr)                       state_nxt = ST_FILL;
      default:                                    state_nxt = ST_FILL;
    endcase
  end

  assign primed = (state == ST_RUN);

  // Stage 3: average, saturate and strobe.
  assign avg   = 17'(sum >>> LOG2_AVG);
  assign sat_w = sat16(avg);

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pos_valid <= 1'b0;
      pos       <= '0;
      pos_sat   <= 1'b0;
    end else begin
      pos_valid <= s2_emit;
      if (s2_emit) begin
        pos     <= sat_w.pos;
        pos_sat <= sat_w.sat;
      end
    end
  end

endmodule

// File: tb/tb_adc_pos_filter.sv
// Scoreboard bench for adc_pos_filter: driver feeds a window-average reference model, monitor checks strobes.
module tb_adc_pos_filter;

  localparam int L2  = 3;
  localparam int WIN = 1 << L2;

  logic        clk_ref   = 1'b0;
  logic        sys_rstn  = 1'b0;
  logic        din_valid = 1'b0;
  logic        cal_req   = 1'b0;
  logic [15:0] din       = 16'h0;
  logic        pos_valid;
  logic [15:0] pos;
  logic        pos_sat;
  logic        primed;

  adc_pos_filter #(
    .LOG2_AVG (L2),
    .OFFSET   (16'h8000)
  ) dut (
    .clk_ref   (clk_ref),
    .sys_rstn  (sys_rstn),
    .din_valid (din_valid),
    .din       (din),
    .cal_req   (cal_req),
    .pos_valid (pos_valid),
    .pos       (pos),
    .pos_sat   (pos_sat),
    .primed    (primed)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    int          cyc;
    logic [15:0] pos;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_strobes = 0;
  int          cyc       = 0;
  logic [15:0] last_pos  = 16'h0;
  logic        last_sat  = 1'b0;

  // Reference model state: the current window of differences as a plain queue.
  int          m_win[$];
  logic [15:0] m_offset;
  bit          m_cal_pend;

  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_win.delete();
    m_offset   = 16'h8000;
    m_cal_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [15:0] d, input logic cal, input int c);
    int   s;
    int   a;
    exp_t e;
    if (cal || m_cal_pend) begin
      m_offset   = d;
      m_cal_pend = 1'b0;
      m_win.delete();
    end else begin
      m_win.push_back(int'(d) - int'(m_offset));
      if (m_win.size() > WIN) void'(m_win.pop_front());
      if (m_win.size() == WIN) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        a = floor_div(s, WIN);
        e.cyc = c + 3;
        if (a > 32767) begin
          e.pos = 16'h7FFF; e.sat = 1'b1;
        end else if (a < -32768) begin
          e.pos = 16'h8000; e.sat = 1'b1;
        end else begin
          e.pos = 16'(a);   e.sat = 1'b0;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // Raise din_valid for 1+hold cycles, then drop it; returns one cycle after the accept.
  task automatic do_accept(input logic [15:0] d, input logic cal, input int hold);
    @(posedge clk_ref); #1;
    din       = d;
    din_valid = 1'b1;
    cal_req   = cal;
    model_accept(d, cal, cyc);
    @(posedge clk_ref); #1;
    cal_req = 1'b0;
    repeat (hold) begin
      @(posedge clk_ref); #1;
    end
    din_valid = 1'b0;
    din       = 16'($urandom);
  endtask

  task automatic pulse_cal();
    @(posedge clk_ref); #1;
    cal_req    = 1'b1;
    m_cal_pend = 1'b1;
    @(posedge clk_ref); #1;
    cal_req = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk_ref);
    #1;
  endtask

  task automatic feed(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) do_accept(d, 1'b0, 0);
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_pos_valid"}, pos_valid, 1'b0);
    chk({tag, "_pos"},       pos,       16'h0);
    chk({tag, "_pos_sat"},   pos_sat,   1'b0);
    chk({tag, "_primed"},    primed,    1'b0);
  endtask

  always @(negedge clk_ref) begin
    if (sys_rstn && pos_valid) begin
      n_strobes++;
      last_pos = pos;
      last_sat = pos_sat;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe actual pos=%h required=no strobe (cycle %0d)", pos, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle",     cyc,     mon_e.cyc);
        chk("pos",              pos,     mon_e.pos);
        chk("pos_sat",          pos_sat, mon_e.sat);
        chk("primed_at_strobe", primed,  1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [15:0] d;
    bit          c;
    model_reset();

    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    chk_outputs_reset("reset");
    @(posedge clk_ref); #1;
    sys_rstn = 1'b1;

    // Fill: 7 silent samples, strobe on the 8th.
    feed(16'h9000, 7);
    drain();
    chk("fill_no_strobe", n_strobes, 0);
    chk("fill_primed_low", primed, 1'b0);
    feed(16'h9000, 1);
    drain();
    chk("fill_strobes", n_strobes, 1);
    chk("fill_pos", last_pos, 16'h1000);
    chk("fill_sat", last_sat, 1'b0);
    chk("fill_primed", primed, 1'b1);

    // Step response.
    feed(16'h7000, 4);
    drain();
    chk("step4_pos", last_pos, 16'h0000);
    feed(16'h7000, 4);
    drain();
    chk("step8_pos", last_pos, 16'hF000);

    // Calibration on the same cycle as the accept.
    do_accept(16'h8123, 1'b1, 0);
    drain();
    chk("cal_same_primed", primed, 1'b0);
    feed(16'h8123, 8);
    drain();
    chk("cal_same_pos", last_pos, 16'h0000);
    chk("cal_same_primed_up", primed, 1'b1);

    // Calibration requested ahead of the accept.
    feed(16'h9999, 2);
    pulse_cal();
    do_accept(16'h8123, 1'b0, 0);
    drain();
    chk("cal_pend_primed", primed, 1'b0);
    feed(16'h8123, 8);
    drain();
    chk("cal_pend_pos", last_pos, 16'h0000);

    // Saturation both ways.
    do_accept(16'h0000, 1'b1, 0);
    feed(16'hFFFF, 8);
    drain();
    chk("sat_hi_pos", last_pos, 16'h7FFF);
    chk("sat_hi_flag", last_sat, 1'b1);
    feed(16'h0000, 8);
    drain();
    chk("sat_zero_pos", last_pos, 16'h0000);
    chk("sat_zero_flag", last_sat, 1'b0);
    do_accept(16'hFFFF, 1'b1, 0);
    feed(16'h0000, 8);
    drain();
    chk("sat_lo_pos", last_pos, 16'h8000);
    chk("sat_lo_flag", last_sat, 1'b1);

    // Held level gives one accept; 2-cycle toggling gives one per accept.
    s0 = n_strobes;
    do_accept(16'h1234, 1'b0, 200);
    drain();
    chk("held_strobes", n_strobes - s0, 1);
    s0 = n_strobes;
    for (int i = 0; i < 16; i++) do_accept(16'($urandom), 1'b0, 0);
    drain();
    chk("toggle_strobes", n_strobes - s0, 16);

    // Reset one cycle after an accept.
    do_accept(16'h5555, 1'b0, 0);
    sys_rstn = 1'b0;
    model_reset();
    @(negedge clk_ref);
    chk_outputs_reset("midreset");
    repeat (3) @(posedge clk_ref);
    #1;
    sys_rstn = 1'b1;
    s0 = n_strobes;
    feed(16'h9000, 7);
    drain();
    chk("refill_no_strobe", n_strobes - s0, 0);
    feed(16'h9000, 1);
    drain();
    chk("refill_strobes", n_strobes - s0, 1);
    chk("refill_pos", last_pos, 16'h1000);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_ref);
      d = 16'($urandom);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) pulse_cal();
      do_accept(d, c, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_primed", primed, (m_win.size() == WIN) ? 1'b1 : 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
